// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: synchronous instruction ROM port plus the decode handshake.
// master = fetch_unit, slave = ROM/decode environment.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            rom_en;
  logic [XLEN-1:0] rom_addr;
  logic [31:0]     rom_data;
  logic [31:0]     instr_out;
  logic [XLEN-1:0] instr_addr;
  logic            instr_valid;
  logic            instr_ready;

  modport master (
    output rom_en, rom_addr, instr_out, instr_addr, instr_valid,
    input  rom_data, instr_ready
  );

  modport slave (
    input  rom_en, rom_addr, instr_out, instr_addr, instr_valid,
    output rom_data, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32 fetch stage: PC, synchronous ROM issue, epoch-tagged return, instruction FIFO to decode.
// Optional FETCH_PERF_COUNTERS_EN adds stall-cycle and redirect counters.
module fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int unsigned     DEPTH      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_out,
  input  logic            bpu_pc_write,
  input  logic [XLEN-1:0] bpu_pc_value,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  input  logic            stall,
  fetch_unit_if.master    bus
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_redirects
`endif
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_addr_q, if_addr_d;
  logic            if_epoch_q, if_epoch_d;
  logic [31:0]     mem_instr_q [DEPTH];
  logic [XLEN-1:0] mem_addr_q  [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            redirect_s, issue_s, ret_s, push_s, pop_s;
  logic [XLEN-1:0] target_s;
  logic [CW:0]     occ_s;

  // Control decode; the occupancy test ignores a same-cycle pop on purpose.
  always_comb begin
    redirect_s = ex_redirect | bpu_pc_write;
    target_s   = ex_redirect ? ex_target : bpu_pc_value;
    occ_s      = {1'b0, count_q} + {{CW{1'b0}}, if_valid_q};
    issue_s    = !redirect_s && !stall && (occ_s < DEPTH_C);
    ret_s      = if_valid_q && !stall && !redirect_s;
    push_s     = ret_s && (if_epoch_q == epoch_q);
    pop_s      = (count_q != {CW{1'b0}}) && bus.instr_ready && !redirect_s;
  end

  // Next-state for PC, epoch, in-flight tag and FIFO bookkeeping.
  always_comb begin
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    if_valid_d = if_valid_q;
    if_addr_d  = if_addr_q;
    if_epoch_d = if_epoch_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_s) begin
      pc_d       = {target_s[XLEN-1:2], 2'b00};
      epoch_d    = ~epoch_q;
      if_valid_d = 1'b0;
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      if (ret_s) begin
        if_valid_d = 1'b0;
      end else begin
        if_valid_d = if_valid_q;
      end
      if (issue_s) begin
        if_valid_d = 1'b1;
        if_addr_d  = pc_q;
        if_epoch_d = epoch_q;
        pc_d       = pc_q + XLEN'(32'd4);
      end else begin
        pc_d       = pc_q;
      end
      wr_ptr_d = push_s ? wr_ptr_q + PW'(1'b1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1'b1) : rd_ptr_q;
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_ADDR;
      epoch_q    <= 1'b0;
      if_valid_q <= 1'b0;
      if_addr_q  <= {XLEN{1'b0}};
      if_epoch_q <= 1'b0;
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      if_valid_q <= if_valid_d;
      if_addr_q  <= if_addr_d;
      if_epoch_q <= if_epoch_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_instr_q[i] <= 32'h0;
        mem_addr_q[i]  <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      mem_instr_q[wr_ptr_q] <= bus.rom_data;
      mem_addr_q[wr_ptr_q]  <= if_addr_q;
    end
  end

  // Outputs; rom_en is gated by rst_n so nothing is requested while held in reset.
  always_comb begin
    pc_out          = pc_q;
    bus.rom_en      = issue_s & rst_n;
    bus.rom_addr    = pc_q;
    bus.instr_valid = (count_q != {CW{1'b0}});
    bus.instr_out   = mem_instr_q[rd_ptr_q];
    bus.instr_addr  = mem_addr_q[rd_ptr_q];
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_stall_q, perf_redir_q;

  // A blocked cycle is any non-redirect cycle in which issue did not fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 32'h0;
      perf_redir_q <= 32'h0;
    end else begin
      perf_stall_q <= perf_stall_q + {31'h0, (!redirect_s && !issue_s)};
      perf_redir_q <= perf_redir_q + {31'h0, redirect_s};
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_redirects    = perf_redir_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan steps plus random traffic, all checked
// against a transaction-level model (queue FIFO, ROM word = address + 1).
module tb_fetch_unit;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned DEPTH      = 4;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_out;
  logic        bpu_pc_write = 1'b0;
  logic [31:0] bpu_pc_value = 32'h0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic        stall = 1'b0;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_stall_cycles, perf_redirects;
`endif

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_out       (pc_out),
    .bpu_pc_write (bpu_pc_write),
    .bpu_pc_value (bpu_pc_value),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .stall        (stall),
    .bus          (bus)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous ROM: returns address + 1, holds its output while rom_en is low.
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= bus.rom_addr + 32'd1;
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_epoch, m_if_valid, m_if_epoch;
  logic [31:0] m_if_addr;
  logic [31:0] m_perf_stall, m_perf_redir;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc         = RESET_ADDR;
    m_epoch      = 1'b0;
    m_if_valid   = 1'b0;
    m_if_epoch   = 1'b0;
    m_if_addr    = 32'h0;
    m_perf_stall = 32'h0;
    m_perf_redir = 32'h0;
  endtask

  // Compare DUT outputs with the model, then apply this cycle's transaction rules.
  task automatic model_cycle();
    logic        redir, iss;
    logic [31:0] tgt;
    int          occ;
    redir = ex_redirect | bpu_pc_write;
    tgt   = ex_redirect ? ex_target : bpu_pc_value;
    occ   = m_q.size() + (m_if_valid ? 1 : 0);
    iss   = !redir && !stall && (occ < DEPTH);
    if (!rst_n) begin
      check("rst_rom_en", {31'h0, bus.rom_en}, 32'h0);
      check("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
      check("rst_pc", pc_out, RESET_ADDR);
    end else begin
      check("rom_en", {31'h0, bus.rom_en}, {31'h0, iss});
      check("rom_addr", bus.rom_addr, m_pc);
      check("pc_out", pc_out, m_pc);
      check("instr_valid", {31'h0, bus.instr_valid}, (m_q.size() > 0) ? 32'h1 : 32'h0);
      if (m_q.size() > 0) begin
        check("instr_addr", bus.instr_addr, m_q[0].addr);
        check("instr_out", bus.instr_out, m_q[0].instr);
      end
    end
`ifdef FETCH_PERF_COUNTERS_EN
    check("perf_stall", perf_stall_cycles, m_perf_stall);
    check("perf_redir", perf_redirects, m_perf_redir);
`endif
    if (!rst_n) begin
      model_reset();
    end else if (redir) begin
      m_q.delete();
      m_if_valid   = 1'b0;
      m_epoch      = ~m_epoch;
      m_pc         = tgt & ~32'h3;
      m_perf_redir = m_perf_redir + 32'd1;
    end else begin
      if (m_q.size() > 0 && bus.instr_ready) void'(m_q.pop_front());
      if (m_if_valid && !stall) begin
        if (m_if_epoch == m_epoch) m_q.push_back('{instr: m_if_addr + 32'd1, addr: m_if_addr});
        m_if_valid = 1'b0;
      end
      if (iss) begin
        m_if_valid = 1'b1;
        m_if_addr  = m_pc;
        m_if_epoch = m_epoch;
        m_pc       = m_pc + 32'd4;
      end else begin
        m_perf_stall = m_perf_stall + 32'd1;
      end
    end
  endtask

  // Inputs are driven at negedge; sample just after, then advance one full cycle.
  task automatic step();
    #1;
    model_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic found;
    model_reset();
    bus.instr_ready = 1'b0;
    @(negedge clk);
    step();
    step();
    check("rst_instr_out", bus.instr_out, 32'h0);
    check("rst_instr_addr", bus.instr_addr, 32'h0);

    // Reset release: back-to-back issue, first word two cycles later
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    #1 check("t1_addr0", bus.rom_addr, 32'h0);
    check("t1_en0", {31'h0, bus.rom_en}, 32'h1);
    step();
    check("t1_addr4", bus.rom_addr, 32'h4);
    step();
    check("t1_addr8", bus.rom_addr, 32'h8);
    check("t1_valid", {31'h0, bus.instr_valid}, 32'h1);
    check("t1_iaddr", bus.instr_addr, 32'h0);
    check("t1_iout", bus.instr_out, 32'h1);
    repeat (3) step();

    // Decode back-pressure fills the FIFO, then drains in order
    reset_pulse();
    bus.instr_ready = 1'b0;
    repeat (10) step();
    #1 check("t2_full_en", {31'h0, bus.rom_en}, 32'h0);
    check("t2_full_valid", {31'h0, bus.instr_valid}, 32'h1);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("t2_drain", bus.instr_addr, 32'(i * 4));
      step();
    end

    // BPU redirect with two buffered words and one in flight
    reset_pulse();
    bus.instr_ready = 1'b0;
    repeat (3) step();
    bpu_pc_write = 1'b1;
    bpu_pc_value = 32'h100;
    step();
    bpu_pc_write = 1'b0;
    #1 check("t3_rom_addr", bus.rom_addr, 32'h100);
    check("t3_flushed", {31'h0, bus.instr_valid}, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (bus.instr_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t3_found", {31'h0, found}, 32'h1);
    check("t3_iaddr", bus.instr_addr, 32'h100);

    // Redirect priority and alignment
    bus.instr_ready = 1'b1;
    ex_redirect = 1'b1; ex_target = 32'h200;
    bpu_pc_write = 1'b1; bpu_pc_value = 32'h300;
    step();
    ex_redirect = 1'b0; bpu_pc_write = 1'b0;
    #1 check("t4_prio", pc_out, 32'h200);
    bpu_pc_write = 1'b1; bpu_pc_value = 32'h1FF;
    step();
    bpu_pc_write = 1'b0;
    #1 check("t4_align", pc_out, 32'h1FC);

    // PC wrap at the top of the address space
    bpu_pc_write = 1'b1; bpu_pc_value = 32'hFFFF_FFFC;
    step();
    bpu_pc_write = 1'b0;
    #1 check("t5_top", bus.rom_addr, 32'hFFFF_FFFC);
    step();
    check("t5_wrap", bus.rom_addr, 32'h0);
    repeat (3) step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      stall           = ($urandom_range(0, 9) < 2);
      bpu_pc_write    = ($urandom_range(0, 19) == 0);
      bpu_pc_value    = $urandom();
      ex_redirect     = ($urandom_range(0, 29) == 0);
      ex_target       = $urandom();
      step();
    end
    stall = 1'b0; bpu_pc_write = 1'b0; ex_redirect = 1'b0;

    // Asynchronous reset with the FIFO full
    bus.instr_ready = 1'b0;
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1 check("t7_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("t7_rom_en", {31'h0, bus.rom_en}, 32'h0);
    check("t7_pc", pc_out, RESET_ADDR);
`ifdef FETCH_PERF_COUNTERS_EN
    check("t7_perf_stall", perf_stall_cycles, 32'h0);
    check("t7_perf_redir", perf_redirects, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    #1 check("t7_restart", bus.rom_addr, RESET_ADDR);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
